// File: rtl/lv_pwm_intb_encode.sv
// lv_pwm_intb_encode
//
// Line-side scheduler for the shared PWM/INTB wire that feeds the low-voltage
// INTB decoder. The enabled interrupt sources are ORed into one desired INTB
// level. Each change of that level is sent as a coded low-pulse burst inside
// the gate wave: one pulse asserts INTB and three pulses release it. Outside
// a burst the wire carries the gate wave, delayed by one register.
//
// Ports:
//   i_clk            block clock
//   i_rst            asynchronous active-high reset
//   i_int_src        interrupt source levels, active high
//   i_int_en         per-source enable mask
//   i_pwm_gwave      gate wave, synchronous to i_clk
//   o_hv_pwm_intb_n  registered line output; high = no pulse
//   o_intb_sent      INTB level last fully transmitted (1 = asserted)
//   o_busy           high while a burst is in progress
//   o_burst_done     one-cycle pulse when a burst finishes
//   o_src_snap       masked sources captured when the burst started
//
// Decoder timing limits: 4 < PULSE_W < 12, GAP_W < 13, GUARD_W > 13.
module lv_pwm_intb_encode #(
  parameter int SRC_NUM = 4,
  parameter int PULSE_W = 8,
  parameter int GAP_W   = 8,
  parameter int GUARD_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [SRC_NUM-1:0] i_int_src,
  input  logic [SRC_NUM-1:0] i_int_en,
  input  logic               i_pwm_gwave,
  output logic               o_hv_pwm_intb_n,
  output logic               o_intb_sent,
  output logic               o_busy,
  output logic               o_burst_done,
  output logic [SRC_NUM-1:0] o_src_snap
);

  localparam int MAX_W = (PULSE_W > GAP_W) ?
                         ((PULSE_W > GUARD_W) ? PULSE_W : GUARD_W) :
                         ((GAP_W > GUARD_W) ? GAP_W : GUARD_W);
  localparam int TMR_W = $clog2(MAX_W + 1);

  localparam logic [TMR_W-1:0] PULSE_T = TMR_W'(PULSE_W);
  localparam logic [TMR_W-1:0] GAP_T   = TMR_W'(GAP_W);
  localparam logic [TMR_W-1:0] GUARD_T = TMR_W'(GUARD_W);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE_LO = 2'd1,
    PULSE_HI = 2'd2,
    GUARD    = 2'd3
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] stable_cnt;
  logic [1:0]       pulse_left;
  logic             target;
  logic             desired;
  logic             start;

  assign desired = |(i_int_src & i_int_en);

  // The gate wave must also be high in the start cycle itself: a fall that
  // coincides with a level change would otherwise slip past the registered
  // stable count and cut the first pulse short on the decoder side.
  assign start = (desired != o_intb_sent) && (stable_cnt == GUARD_T) &&
                 i_pwm_gwave;

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      timer           <= '0;
      stable_cnt      <= '0;
      pulse_left      <= 2'd0;
      target          <= 1'b0;
      o_hv_pwm_intb_n <= 1'b1;
      o_intb_sent     <= 1'b0;
      o_burst_done    <= 1'b0;
      o_src_snap      <= '0;
    end else begin
      o_burst_done <= 1'b0;

      // Gate-wave high-stable counter runs in every state.
      if (!i_pwm_gwave) begin
        stable_cnt <= '0;
      end else if (stable_cnt != GUARD_T) begin
        stable_cnt <= stable_cnt + TMR_ONE;
      end

      case (state)
        IDLE: begin
          o_hv_pwm_intb_n <= i_pwm_gwave;
          if (start) begin
            state           <= PULSE_LO;
            timer           <= PULSE_T;
            pulse_left      <= desired ? 2'd1 : 2'd3;
            target          <= desired;
            o_src_snap      <= i_int_src & i_int_en;
            o_hv_pwm_intb_n <= 1'b0;
          end
        end

        // Timers count PULSE_W/GAP_W/GUARD_W down to 1, so each state
        // occupies exactly that many cycles; the line is set on entry.
        PULSE_LO: begin
          if (timer == TMR_ONE) begin
            pulse_left      <= pulse_left - 2'd1;
            o_hv_pwm_intb_n <= 1'b1;
            if (pulse_left == 2'd1) begin
              state <= GUARD;
              timer <= GUARD_T;
            end else begin
              state <= PULSE_HI;
              timer <= GAP_T;
            end
          end else begin
            timer <= timer - TMR_ONE;
          end
        end

        PULSE_HI: begin
          if (timer == TMR_ONE) begin
            state           <= PULSE_LO;
            timer           <= PULSE_T;
            o_hv_pwm_intb_n <= 1'b0;
          end else begin
            timer <= timer - TMR_ONE;
          end
        end

        GUARD: begin
          if (timer == TMR_ONE) begin
            state           <= IDLE;
            timer           <= '0;
            o_intb_sent     <= target;
            o_burst_done    <= 1'b1;
            o_hv_pwm_intb_n <= i_pwm_gwave;
          end else begin
            timer <= timer - TMR_ONE;
          end
        end

        default: begin
          state           <= IDLE;
          timer           <= '0;
          o_hv_pwm_intb_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lv_pwm_intb_encode.sv
module tb_lv_pwm_intb_encode;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src;
  logic [3:0] en;
  logic       gwave;
  logic       line;
  logic       sent;
  logic       busy;
  logic       done;
  logic [3:0] snap;

  int n_chk  = 0;
  int n_fail = 0;

  bit pat_q[$];

  typedef struct {
    logic [3:0] src;
    logic [3:0] en;
    int         kind;   // 0 = no burst, 1 = assert burst, 2 = release burst
    logic [3:0] snap;
    logic       sent;
  } vec_t;

  vec_t tbl[8];

  lv_pwm_intb_encode #(
    .SRC_NUM(4),
    .PULSE_W(8),
    .GAP_W  (8),
    .GUARD_W(16)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_int_src      (src),
    .i_int_en       (en),
    .i_pwm_gwave    (gwave),
    .o_hv_pwm_intb_n(line),
    .o_intb_sent    (sent),
    .o_busy         (busy),
    .o_burst_done   (done),
    .o_src_snap     (snap)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line shape of a burst is queued when the level change is driven,
  // then popped and compared cycle by cycle once the line drops.
  task automatic run_burst(input bit rel, input int exp_lat, input logic [3:0] exp_snap,
                           input int glitch_at, input int gfall_at);
    int lat;
    int len;
    int busy_n;
    bit e;
    pat_q.delete();
    if (!rel) begin
      repeat (8)  pat_q.push_back(1'b0);
      repeat (16) pat_q.push_back(1'b1);
    end else begin
      for (int p = 0; p < 3; p++) begin
        repeat (8) pat_q.push_back(1'b0);
        if (p < 2) repeat (8) pat_q.push_back(1'b1);
      end
      repeat (16) pat_q.push_back(1'b1);
    end
    len = pat_q.size();
    lat = 0;
    while (line !== 1'b0 && lat < 100) begin
      tick();
      lat++;
    end
    chk("burst_start_latency", 32'(lat), 32'(exp_lat));
    if (line !== 1'b0) return;
    busy_n = 0;
    for (int k = 0; k < len; k++) begin
      e = pat_q.pop_front();
      chk("line_pattern", 32'(line), 32'(e));
      if (busy === 1'b1) busy_n++;
      if (glitch_at >= 0 && k == glitch_at)     src = 4'b0001;
      if (glitch_at >= 0 && k == glitch_at + 3) src = 4'b0000;
      if (gfall_at >= 0 && k == gfall_at)       gwave = 1'b0;
      tick();
    end
    chk("busy_cycles", 32'(busy_n), 32'(len));
    chk("burst_done_pulse", 32'(done), 32'd1);
    chk("busy_after_burst", 32'(busy), 32'd0);
    chk("intb_sent", 32'(sent), 32'(!rel));
    chk("src_snap", 32'(snap), 32'(exp_snap));
    tick();
    chk("burst_done_clear", 32'(done), 32'd0);
  endtask

  task automatic run_idle(input int n);
    int lows;
    int busys;
    lows  = 0;
    busys = 0;
    repeat (n) begin
      tick();
      if (line !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    chk("idle_line_low_cycles", 32'(lows), 32'd0);
    chk("idle_busy_cycles", 32'(busys), 32'd0);
  endtask

  initial begin
    int mirror_err;
    int busy_err;

    tbl[0] = '{src: 4'b1010, en: 4'b0101, kind: 0, snap: 4'b0000, sent: 1'b0};
    tbl[1] = '{src: 4'b1010, en: 4'b0010, kind: 1, snap: 4'b0010, sent: 1'b1};
    tbl[2] = '{src: 4'b1110, en: 4'b1110, kind: 0, snap: 4'b0010, sent: 1'b1};
    tbl[3] = '{src: 4'b1010, en: 4'b0000, kind: 2, snap: 4'b0000, sent: 1'b0};
    tbl[4] = '{src: 4'b0001, en: 4'b1111, kind: 1, snap: 4'b0001, sent: 1'b1};
    tbl[5] = '{src: 4'b1000, en: 4'b0111, kind: 2, snap: 4'b0000, sent: 1'b0};
    tbl[6] = '{src: 4'b1111, en: 4'b1111, kind: 1, snap: 4'b1111, sent: 1'b1};
    tbl[7] = '{src: 4'b0001, en: 4'b0001, kind: 0, snap: 4'b1111, sent: 1'b1};

    rst   = 1'b1;
    gwave = 1'b1;
    src   = 4'b0000;
    en    = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_line", 32'(line), 32'd1);
    chk("reset_sent", 32'(sent), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_snap", 32'(snap), 32'd0);

    // First assert burst after 16 stable gate-wave cycles.
    src = 4'b0100;
    rst = 1'b0;
    run_burst(1'b0, 17, 4'b0100, -1, -1);

    // Release burst with a 3-cycle source glitch in the middle.
    src = 4'b0000;
    run_burst(1'b1, 1, 4'b0000, 20, -1);
    run_idle(30);

    // Desired change together with a gate-wave fall, then period-10 toggling.
    src = 4'b0001;
    mirror_err = 0;
    busy_err   = 0;
    for (int i = 0; i < 45; i++) begin
      gwave = ((i / 5) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      if (line !== gwave) mirror_err++;
      if (busy !== 1'b0) busy_err++;
    end
    chk("gwave_mirror_errors", 32'(mirror_err), 32'd0);
    chk("busy_while_toggling", 32'(busy_err), 32'd0);
    gwave = 1'b1;
    tick();
    chk("line_follows_gwave_high", 32'(line), 32'd1);
    run_burst(1'b0, 16, 4'b0001, -1, -1);

    // Gate wave falls during the first gap of a release burst.
    src = 4'b0000;
    run_burst(1'b1, 1, 4'b0000, -1, 12);
    chk("line_follows_gwave_low", 32'(line), 32'd0);
    gwave = 1'b1;
    run_idle(20);

    for (int i = 0; i < 8; i++) begin
      src = tbl[i].src;
      en  = tbl[i].en;
      if (tbl[i].kind == 0) run_idle(30);
      else run_burst(tbl[i].kind == 2, 1, tbl[i].snap, -1, -1);
      chk("table_sent", 32'(sent), 32'(tbl[i].sent));
    end

    // Reset in the 4th cycle of the first low pulse of a release burst.
    src = 4'b0000;
    tick();
    chk("pulse_lo_before_reset", 32'(line), 32'd0);
    repeat (3) tick();
    chk("pulse_lo_cycle4", 32'(line), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_line", 32'(line), 32'd1);
    chk("async_reset_sent", 32'(sent), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_done", 32'(done), 32'd0);
    src = 4'b0100;
    en  = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_burst(1'b0, 17, 4'b0100, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
